// File: rtl/raybox_spi_pkg.sv
// raybox_spi_pkg: shared constants, state encoding and POV frame layout for the SPI master.
package raybox_spi_pkg;
    localparam int POV_BITS = 74;
    localparam int PLAYER_W = 15;
    localparam int FACING_W = 11;
    localparam int VPLANE_W = 11;

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TAIL, GAP} spi_state_e;

    // Packs the POV fields MSB-first: player X/Y, facing X/Y, vplane X/Y.
    function automatic logic [POV_BITS-1:0] pov_frame(
        input logic [PLAYER_W-1:0] px, py,
        input logic [FACING_W-1:0] fx, fy,
        input logic [VPLANE_W-1:0] vx, vy
    );
        return {px, py, fx, fy, vx, vy};
    endfunction
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: counts HALF clk cycles per phase and flags the last cycle of each.
module spi_half_tick #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    logic [7:0] cnt;

    assign tick = cnt == 8'(HALF - 1);

    always_ff @(posedge clk) begin
        if (reset || restart) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 8'd1;
    end
endmodule

// File: rtl/pov_spi_master.sv
// pov_spi_master: mode-0 SPI master sending a left-justified frame of up to MAX_BITS bits, MSB first.
module pov_spi_master
    import raybox_spi_pkg::*;
#(
    parameter int MAX_BITS = POV_BITS,
    parameter int HALF     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MAX_BITS-1:0] tx_data,
    input  logic [6:0]          tx_len,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                done,
    output logic                sclk,
    output logic                mosi,
    output logic                ss_n
);
    spi_state_e          state, state_n;
    logic [MAX_BITS-1:0] shift, shift_n;
    logic [6:0]          bits, bits_n, len_eff;
    logic                tick, active;

    spi_half_tick #(.HALF(HALF)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(state == IDLE),
        .tick   (tick)
    );

    assign len_eff = (tx_len == 7'd0 || tx_len > 7'(MAX_BITS)) ? 7'(MAX_BITS) : tx_len;
    assign active  = state_n inside {LEAD, HIGH, LOW, TAIL};

    always_comb begin
        state_n = state;
        shift_n = shift;
        bits_n  = bits;
        case (state)
            IDLE: if (tx_valid && tx_ready) begin
                state_n = LEAD;
                shift_n = tx_data;
                bits_n  = len_eff;
            end
            LEAD: if (tick) state_n = HIGH;
            HIGH: if (tick) begin
                bits_n  = bits - 7'd1;
                state_n = (bits == 7'd1) ? TAIL : LOW;
                shift_n = (bits == 7'd1) ? shift : {shift[MAX_BITS-2:0], 1'b0};
            end
            LOW:  if (tick) state_n = HIGH;
            TAIL: if (tick) state_n = GAP;
            GAP:  if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bits     <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 1'b1;
            done     <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bits     <= bits_n;
            sclk     <= state_n == HIGH;
            mosi     <= active && shift_n[MAX_BITS-1];
            ss_n     <= !active;
            done     <= state_n == GAP && state != GAP;
            tx_ready <= state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_pov_spi_master.sv
// tb_pov_spi_master: directed checks of frame timing, data, clamping, back-to-back and reset abort.
module tb_pov_spi_master;
    import raybox_spi_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [73:0] tx_data = '0;
    logic [6:0]  tx_len = '0;
    logic [2:0]  tx_valid = '0;
    logic [2:0]  tx_ready, done, sclk, mosi, ss_n;

    int n_cmp = 0, n_bad = 0;
    logic [73:0] rx;
    int rises, low_n, first_low, first_rise, done_at, rdy_at, glitch;

    always #5 clk = ~clk;

    pov_spi_master #(.HALF(2)) dut_h2 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_len(tx_len), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .done(done[0]), .sclk(sclk[0]), .mosi(mosi[0]), .ss_n(ss_n[0])
    );
    pov_spi_master #(.HALF(1)) dut_h1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_len(tx_len), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .done(done[1]), .sclk(sclk[1]), .mosi(mosi[1]), .ss_n(ss_n[1])
    );
    pov_spi_master #(.HALF(3)) dut_h3 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_len(tx_len), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .done(done[2]), .sclk(sclk[2]), .mosi(mosi[2]), .ss_n(ss_n[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one frame on instance i and records what a mode-0 slave would see.
    // Cycle t counts from the acceptance edge; abort>0 returns once that many bits have been clocked.
    task automatic xfer(input int i, input logic [73:0] d, input logic [6:0] l,
                        input bit hold, input logic [73:0] d_mid, input int abort);
        logic [73:0] acc;
        logic ps, pm;
        int guard;
        guard = 0;
        while (!tx_ready[i] && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        tx_data = d;
        tx_len = l;
        tx_valid[i] = 1'b1;
        acc = '0; ps = 1'b0; pm = 1'b0;
        rises = 0; low_n = 0; first_low = -1; first_rise = -1; done_at = -1; rdy_at = -1; glitch = 0;
        for (int t = 1; t <= 1000; t++) begin
            @(negedge clk);
            if (t == 1 && !hold) tx_valid[i] = 1'b0;
            if (t == 5) begin
                tx_data = hold ? d_mid : ~d;
                if (!hold) tx_len = 7'd3;
            end
            if (!ss_n[i]) begin
                low_n++;
                if (first_low < 0) first_low = t;
            end
            if (sclk[i] && !ps) begin
                rises++;
                acc = {acc[72:0], mosi[i]};
                if (first_rise < 0) first_rise = t;
            end
            if ((sclk[i] && ps && mosi[i] !== pm) || (sclk[i] && ss_n[i])) glitch++;
            if (done[i]) begin
                if (done_at < 0) done_at = t;
                else glitch++;
            end
            ps = sclk[i];
            pm = mosi[i];
            if (abort > 0 && rises == abort) break;
            if (t > 1 && tx_ready[i]) begin
                rdy_at = t;
                break;
            end
        end
        rx = (rises > 0 && rises <= 74) ? acc << (74 - rises) : acc;
    endtask

    initial begin
        logic [73:0] f1, f2, f4a, f4b, f5;
        int done1, rdy1, extra;
        f1  = 74'h2_AAAA_5555_F0F0_0F0F;
        f2  = {14'b10_1100_0000_0011, 60'b0};
        f4a = {20'hA5C3F, 54'b0};
        f4b = {20'h3C5A1, 54'b0};
        f5  = pov_frame(15'h1234, 15'h7ABC, 11'h3FF, 11'h001, 11'h555, 11'h2AA);

        repeat (3) @(negedge clk);
        check("reset_h2", {ss_n[0], sclk[0], mosi[0], tx_ready[0], done[0]}, 5'b10010);
        check("reset_h1", {ss_n[1], sclk[1], mosi[1], tx_ready[1], done[1]}, 5'b10010);
        check("reset_h3", {ss_n[2], sclk[2], mosi[2], tx_ready[2], done[2]}, 5'b10010);
        reset = 1'b0;
        @(negedge clk);

        xfer(0, f1, 7'd0, 1'b0, '0, 0);
        check("pov_data", rx, f1);
        check("pov_rises", rises, 74);
        check("pov_ss_first", first_low, 1);
        check("pov_ss_len", low_n, 298);
        check("pov_rise0", first_rise, 3);
        check("pov_done", done_at, 299);
        check("pov_ready", rdy_at, 301);
        check("pov_glitch", glitch, 0);

        xfer(1, f2, 7'd14, 1'b0, '0, 0);
        check("reg_data", rx, f2);
        check("reg_rises", rises, 14);
        check("reg_ss_len", low_n, 29);
        check("reg_rise0", first_rise, 2);
        check("reg_done", done_at, 30);
        check("reg_ready", rdy_at, 31);

        xfer(1, f1, 7'd100, 1'b0, '0, 0);
        check("clamp100_rises", rises, 74);
        check("clamp100_data", rx, f1);
        check("clamp100_ss", low_n, 149);
        xfer(1, f1, 7'd74, 1'b0, '0, 0);
        check("len74_rises", rises, 74);
        check("len74_data", rx, f1);

        xfer(1, f4a, 7'd20, 1'b1, f4b, 0);
        done1 = done_at;
        rdy1 = rdy_at;
        check("b2b_first_data", rx, f4a);
        check("b2b_first_rises", rises, 20);
        check("b2b_gap", rdy1 - done1 + 1, 2);
        xfer(1, f4b, 7'd20, 1'b0, '0, 0);
        check("b2b_second_start", first_low, 1);
        check("b2b_second_data", rx, f4b);

        xfer(0, f1, 7'd0, 1'b0, '0, 30);
        check("abort_bits", rises, 30);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", {ss_n[0], sclk[0], mosi[0], tx_ready[0], done[0]}, 5'b10010);
        reset = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done[0] || !ss_n[0]) extra++;
        end
        check("abort_no_done", extra, 0);
        xfer(0, f5, 7'd0, 1'b0, '0, 0);
        check("after_abort_data", rx, f5);
        check("after_abort_done", done_at, 299);

        xfer(2, f1, 7'd0, 1'b0, '0, 0);
        check("h3_data", rx, f1);
        check("h3_glitch", glitch, 0);
        check("h3_ss_len", low_n, 447);
        check("h3_done", done_at, 448);
        check("h3_ready", rdy_at, 451);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pov_spi_master.md
# pov_spi_master

SPI master that serialises a left-justified frame of up to 74 bits, MSB first, onto a 3-wire SPI link (sclk/mosi/ss_n). It drives the raybox-zero POV slave port (pov_sclk/pov_mosi/pov_ss_n, full 74-bit POV frame) or the register slave port (reg_sclk/reg_mosi/reg_ss_n, shorter frames). It sits in the companion controller and in the cocotb/Verilog bench as the transmitting end of those ports, replacing bit-banged stimulus. Frames are accepted through a valid/ready handshake and one `done` pulse marks each completed frame.

## Interface
- MAX_BITS, 74: frame register width; full POV frame length.
- HALF, 2: sclk half-period in clk cycles; legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  MAX_BITS  frame payload, left-justified (bit MAX_BITS-1 sent first).
- tx_len  in  7  number of bits to send.
- tx_valid  in  1  request; frame accepted on a cycle with tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse on the first cycle ss_n is high after a frame.
- sclk  out  1  SPI clock, idle low (mode 0).
- mosi  out  1  SPI data; changes only while sclk is low.
- ss_n  out  1  active-low select, idle high.

## Operation
- States: IDLE, LEAD, HIGH, LOW, TAIL, GAP. A half-period counter (0..HALF-1) advances the state at HALF-1.
- IDLE: tx_ready=1, ss_n=1, sclk=0, mosi=0. On acceptance, capture tx_data into the shift register and the effective length into the bit counter, then go to LEAD.
- Effective length: tx_len==0 or tx_len>MAX_BITS becomes MAX_BITS; otherwise tx_len.
- LEAD (HALF cycles): ss_n=0, sclk=0, mosi=shift[MSB].
- HIGH (HALF cycles): sclk=1, mosi held. At the end, decrement the bit counter. If bits remain, go to LOW; else go to TAIL.
- LOW (HALF cycles): sclk=0. On entry, shift left by one, so the new MSB drives mosi. Then go to HIGH.
- TAIL (HALF cycles): sclk=0, ss_n=0, mosi held. Then go to GAP.
- GAP (HALF cycles): ss_n=1, sclk=0, mosi=0. done=1 on the first GAP cycle only. Then go to IDLE.
- tx_data and tx_len are ignored outside the acceptance cycle. tx_valid held high while busy has no effect. Back-to-back frames are separated by at least HALF+1 cycles of ss_n high (GAP plus the IDLE accept cycle).
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset (any cycle, including mid-frame): on the next clk edge, IDLE, ss_n=1, sclk=0, mosi=0, done=0, tx_ready=1. No done pulse for an aborted frame; the slave sees a short frame that it discards.
- Let the acceptance edge be cycle 0, N the effective length, and H = HALF.
- ss_n low from cycle 1 through cycle (2N+1)·H inclusive.
- Rising sclk edge k (k=0..N-1) is at cycle 1+H+2kH; bit MAX_BITS-1-k is stable H cycles before and H cycles after it.
- done=1 at cycle (2N+1)·H+1.
- tx_ready=1 again at cycle (2N+2)·H+1.
- N=74, H=2: ss_n low for cycles 1..298, done at 299, tx_ready at 301.

## Structure
- Shared package raybox_spi_pkg:
  - POV_BITS=74.
  - State encoding (IDLE..GAP).
  - Frame field widths for POV: player X/Y 15 bits each, facing X/Y 11 bits each, vplane X/Y 11 bits each, MSB-first in that order.
- One sub-module, spi_half_tick: the HALF-cycle counter with a sync reset and restart input, producing a `tick` on the last cycle of each phase.
- The FSM, shift register and bit counter live in pov_spi_master.

## Test plan
- Full POV, H=2: tx_data=74'h2_AAAA_5555_F0F0_0F0F, tx_len=0. Bench slave samples mosi on sclk rise and gets the same 74 bits. ss_n low exactly 298 cycles; done at cycle 299; tx_ready at 301.
- Short reg frame, H=1: tx_len=14, tx_data top bits 14'b10_1100_0000_0011. Exactly 14 sclk rising edges with that pattern; ss_n low 29 cycles; done at cycle 30.
- Length clamp: tx_len=100 gives 74 sclk rises, identical to tx_len=74.
- Back-to-back: tx_valid held high with two payloads. The second is accepted at the cycle tx_ready returns. ss_n high for exactly H+1 cycles between frames. Changing tx_data mid-frame does not alter the first frame.
- Reset mid-frame after 30 bits, H=2: next cycle ss_n=1, sclk=0, mosi=0, tx_ready=1, and no done pulse. A subsequent full frame transfers correctly.
- Continuous check with H=3: mosi never changes while sclk=1, and sclk is never high while ss_n=1.
